// File: rtl/return_stack.sv
// Return-address LIFO for the sequencer: CALL pushes PC+1, RET pops it back onto rd_data.
// Stack pointer equals count; rejected operations set sticky flags and leave contents intact.
module return_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // push and pop are single-cycle strobes with no ready: the block always accepts,
  // and rejects misuse by flagging. rd_valid qualifies rd_data for exactly one cycle.

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic             is_empty;
  logic             is_full;

  // Low bits wrap DEPTH to 0, so top_idx is DEPTH-1 when full.
  assign wr_idx   = count_q[AW-1:0];
  assign top_idx  = count_q[AW-1:0] - AW'(1);
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

  always_comb begin
    mem_d       = mem_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q & ~clr_err;
    underflow_d = underflow_q & ~clr_err;
    case ({push, pop})
      2'b10: begin
        if (is_full) begin
          overflow_d = 1'b1;
        end else begin
          mem_d[wr_idx] = push_data;
          count_d       = count_q + CW'(1);
        end
      end
      2'b01: begin
        if (is_empty) begin
          underflow_d = 1'b1;
        end else begin
          rd_data_d  = mem_q[top_idx];
          rd_valid_d = 1'b1;
          count_d    = count_q - CW'(1);
        end
      end
      2'b11: begin
        rd_valid_d = 1'b1;
        if (is_empty) begin
          rd_data_d = push_data;
        end else begin
          // RET then CALL merged: return old top, replace it in place.
          rd_data_d      = mem_q[top_idx];
          mem_d[top_idx] = push_data;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Contents are don't-care after reset; count alone defines validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign top       = is_empty ? '0 : mem_q[top_idx];
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_return_stack.sv
// Directed bench for return_stack: LIFO order, full/empty rejection, sticky flags,
// merged push+pop and asynchronous reset in the middle of a pop.
module tb_return_stack;

  logic       clk;
  logic       rst;
  logic       push;
  logic       pop;
  logic [7:0] push_data;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [7:0] top;
  logic [3:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  return_stack #(.WIDTH(8), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .clr_err   (clr_err),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .top       (top),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Driver: apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic do_op(input logic p, input logic q, input logic [7:0] d, input logic c);
    push      = p;
    pop       = q;
    push_data = d;
    clr_err   = c;
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic do_push(input logic [7:0] d);
    do_op(1'b1, 1'b0, d, 1'b0);
  endtask

  task automatic do_pop();
    do_op(1'b0, 1'b1, 8'h00, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    push = 1'b0;
    pop = 1'b0;
    push_data = 8'h00;
    clr_err = 1'b0;
    #22;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_underflow", underflow, 0);
    check("rst_top", top, 0);

    // Basic LIFO order
    do_push(8'h11);
    do_push(8'h22);
    do_push(8'h33);
    check("t1_count", count, 3);
    check("t1_top", top, 8'h33);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h11);
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      do_pop();
      check("t1_pop_valid", rd_valid, 1);
      check("t1_pop_data", rd_data, e);
    end
    @(posedge clk);
    #1;
    check("t1_valid_pulse", rd_valid, 0);
    check("t1_empty", empty, 1);
    check("t1_underflow", underflow, 0);

    // Fill, overflow, sticky/clear behaviour
    for (int i = 1; i <= 8; i++) do_push(8'(i));
    check("t2_full", full, 1);
    check("t2_empty_when_full", empty, 0);
    do_push(8'hFF);
    check("t2_overflow", overflow, 1);
    check("t2_count", count, 8);
    check("t2_top", top, 8'h08);
    do_op(1'b1, 1'b0, 8'hEE, 1'b1);
    check("t2_set_wins", overflow, 1);
    check("t2_top_after", top, 8'h08);
    do_op(1'b0, 1'b0, 8'h00, 1'b1);
    check("t2_clr", overflow, 0);
    do_pop();
    check("t2_pop_data", rd_data, 8'h08);
    check("t2_pop_count", count, 7);
    for (int i = 7; i >= 1; i--) begin
      do_pop();
      check("t2_drain_data", rd_data, 8'(i));
    end
    check("t2_drained", empty, 1);

    // Underflow
    do_pop();
    check("t3_underflow", underflow, 1);
    check("t3_rd_valid", rd_valid, 0);
    check("t3_rd_data_hold", rd_data, 8'h01);
    do_push(8'h5A);
    check("t3_count", count, 1);
    check("t3_sticky", underflow, 1);
    do_op(1'b0, 1'b0, 8'h00, 1'b1);
    check("t3_clr", underflow, 0);
    do_pop();
    check("t3_pop_data", rd_data, 8'h5A);

    // Merged push+pop
    do_push(8'h10);
    do_push(8'h20);
    do_op(1'b1, 1'b1, 8'h99, 1'b0);
    check("t4_rd_data", rd_data, 8'h20);
    check("t4_rd_valid", rd_valid, 1);
    check("t4_count", count, 2);
    check("t4_top", top, 8'h99);
    for (int i = 3; i <= 8; i++) do_push(8'(i * 16));
    check("t4_full", full, 1);
    do_op(1'b1, 1'b1, 8'hC3, 1'b0);
    check("t4_full_rd_data", rd_data, 8'h80);
    check("t4_full_count", count, 8);
    check("t4_full_overflow", overflow, 0);
    check("t4_full_top", top, 8'hC3);
    for (int i = 0; i < 7; i++) do_pop();
    check("t4_second", rd_data, 8'h99);
    do_pop();
    check("t4_bottom", rd_data, 8'h10);
    check("t4_empty", empty, 1);

    // Pass-through on empty
    do_op(1'b1, 1'b1, 8'h42, 1'b0);
    check("t5_rd_data", rd_data, 8'h42);
    check("t5_rd_valid", rd_valid, 1);
    check("t5_count", count, 0);
    check("t5_overflow", overflow, 0);
    check("t5_underflow", underflow, 0);

    // Asynchronous reset while a pop is in flight
    do_push(8'hAA);
    do_push(8'hBB);
    push = 1'b0;
    pop  = 1'b1;
    @(posedge clk);
    #1;
    check("t6_pre_valid", rd_valid, 1);
    check("t6_pre_data", rd_data, 8'hBB);
    #2;
    rst = 1'b1;
    #1;
    check("t6_count", count, 0);
    check("t6_rd_valid", rd_valid, 0);
    check("t6_rd_data", rd_data, 0);
    check("t6_top", top, 0);
    #1;
    pop = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_pop();
    check("t6_underflow", underflow, 1);
    check("t6_no_valid", rd_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
